// File: rtl/dbf_sched_pkg.sv
// Shared definitions for the DBF beam scheduler: FSM encoding, default sizes
// and the packed weight-table word layout {cut, real, imag}.
package dbf_sched_pkg;

    localparam int NBEAM_DEF = 16;
    localparam int AW_DEF    = 4;
    localparam int WORD_W    = 35;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [2:0]  cut;
        logic [15:0] re;
        logic [15:0] im;
    } wt_word_t;

endpackage

// File: rtl/dbf_wt_ram.sv
// Beam weight table: one write port, one registered read port. A read and a
// write to the same address on the same edge returns the previous contents.
module dbf_wt_ram
    import dbf_sched_pkg::*;
#(
    parameter int NBEAM = NBEAM_DEF,
    parameter int AW    = AW_DEF
)(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  wt_word_t      i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output wt_word_t      o_rdata
);

    wt_word_t r_mem [NBEAM];
    wt_word_t r_rdata;

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dbf_fy_beam_sched.sv
// Frame scheduler for the beamforming weight datapath: steps through beams,
// presents each beam's weights and gates the raw sample stream per beam window.
//
// state | meaning
// IDLE  | waiting for prt_start
// LOAD  | one cycle, reading weight entry beam_idx
// RUN   | gating win_len valid samples for the current beam
// DONE  | one-cycle frame_done pulse, then back to IDLE
module dbf_fy_beam_sched
    import dbf_sched_pkg::*;
#(
    parameter int NBEAM = NBEAM_DEF,
    parameter int AW    = AW_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [15:0]   cfg_real,
    input  logic [15:0]   cfg_imag,
    input  logic [2:0]    cfg_cut,
    input  logic [AW:0]   beam_num,
    input  logic [15:0]   win_len,
    input  logic          prt_start,
    input  logic          data_in_valid,
    output logic [15:0]   ph_real,
    output logic [15:0]   ph_image,
    output logic          phase_data_valid,
    output logic [2:0]    fy_cut_ctl,
    output logic          data_gate_valid,
    output logic [AW-1:0] beam_idx,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overrun
);

    localparam logic [AW:0] BN_MAX = (AW+1)'(NBEAM);
    localparam logic [AW:0] BN_ONE = (AW+1)'(1);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [AW:0]   r_beam_num;
    logic [15:0]   r_win_len;
    logic [15:0]   r_smp_cnt;
    logic [AW-1:0] r_beam_idx;
    logic          r_pdv;
    logic          r_err;

    logic [AW:0]   w_bn_clamp;
    logic [15:0]   w_wl_clamp;
    logic          w_start;
    logic          w_load;
    logic          w_gate;
    logic          w_win_end;
    logic          w_last_beam;
    wt_word_t      w_wdata;
    wt_word_t      w_rdata;

    always_comb begin
        w_bn_clamp = beam_num;
        if (beam_num == '0 || beam_num > BN_MAX) begin
            w_bn_clamp = BN_MAX;
        end
        w_wl_clamp = (win_len == 16'd0) ? 16'd1 : win_len;
    end

    assign w_start     = prt_start && (r_state == ST_IDLE);
    assign w_load      = (r_state == ST_LOAD);
    assign w_win_end   = w_gate && (r_smp_cnt == r_win_len - 16'd1);
    assign w_last_beam = ({1'b0, r_beam_idx} == r_beam_num - BN_ONE);

    always_comb begin
        w_state_nxt     = r_state;
        w_gate          = 1'b0;
        busy            = 1'b1;
        frame_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (prt_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_gate = data_in_valid;
                if (w_win_end) begin
                    w_state_nxt = w_last_beam ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beam_num <= '0;
            r_win_len  <= '0;
            r_smp_cnt  <= '0;
            r_beam_idx <= '0;
            r_pdv      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pdv   <= w_load;
            r_err   <= prt_start && busy;
            // Frame geometry is frozen here until the next accepted start.
            if (w_start) begin
                r_beam_num <= w_bn_clamp;
                r_win_len  <= w_wl_clamp;
                r_beam_idx <= '0;
            end else if (w_win_end && !w_last_beam) begin
                r_beam_idx <= r_beam_idx + AW'(1);
            end
            if (w_load) begin
                r_smp_cnt <= '0;
            end else if (w_gate) begin
                r_smp_cnt <= r_smp_cnt + 16'd1;
            end
        end
    end

    assign w_wdata = {cfg_cut, cfg_real, cfg_imag};

    dbf_wt_ram #(
        .NBEAM (NBEAM),
        .AW    (AW)
    ) u_wt_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wdata (w_wdata),
        .i_re    (w_load),
        .i_raddr (r_beam_idx),
        .o_rdata (w_rdata)
    );

    assign ph_real          = w_rdata.re;
    assign ph_image         = w_rdata.im;
    assign fy_cut_ctl       = w_rdata.cut;
    assign phase_data_valid = r_pdv;
    assign data_gate_valid  = w_gate;
    assign beam_idx         = r_beam_idx;
    assign err_overrun      = r_err;

endmodule

// File: tb/tb_dbf_fy_beam_sched.sv
// Scoreboard bench for dbf_fy_beam_sched: expected weight outputs are queued
// at frame start and matched against each phase_data_valid pulse.
`timescale 1ns/1ps
module tb_dbf_fy_beam_sched;

    localparam int NB  = 16;
    localparam int AWB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [AWB-1:0] cfg_addr = '0;
    logic [15:0]    cfg_real = '0;
    logic [15:0]    cfg_imag = '0;
    logic [2:0]     cfg_cut = '0;
    logic [AWB:0]   beam_num = '0;
    logic [15:0]    win_len = '0;
    logic           prt_start = 1'b0;
    logic           data_in_valid = 1'b0;
    logic [15:0]    ph_real;
    logic [15:0]    ph_image;
    logic           phase_data_valid;
    logic [2:0]     fy_cut_ctl;
    logic           data_gate_valid;
    logic [AWB-1:0] beam_idx;
    logic           busy;
    logic           frame_done;
    logic           err_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int gated_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_gv_cyc = 0;
    int done_cyc = 0;

    logic [34:0] tab [NB];
    logic [38:0] exp_q [$];
    logic [38:0] obs_q [$];
    logic [3:0]  gvb_q [$];

    dbf_fy_beam_sched #(.NBEAM(NB), .AW(AWB)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_real         (cfg_real),
        .cfg_imag         (cfg_imag),
        .cfg_cut          (cfg_cut),
        .beam_num         (beam_num),
        .win_len          (win_len),
        .prt_start        (prt_start),
        .data_in_valid    (data_in_valid),
        .ph_real          (ph_real),
        .ph_image         (ph_image),
        .phase_data_valid (phase_data_valid),
        .fy_cut_ctl       (fy_cut_ctl),
        .data_gate_valid  (data_gate_valid),
        .beam_idx         (beam_idx),
        .busy             (busy),
        .frame_done       (frame_done),
        .err_overrun      (err_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (phase_data_valid) obs_q.push_back({beam_idx, fy_cut_ctl, ph_real, ph_image});
            if (data_gate_valid) begin
                gated_cnt++;
                gvb_q.push_back(beam_idx);
                last_gv_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_overrun) err_cnt++;
        end
    end

    task automatic write_entry(input int a, input logic [34:0] w);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_addr = AWB'(a);
        {cfg_cut, cfg_real, cfg_imag} = w;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tab[a] = w;
    endtask

    task automatic start_frame(input int bn, input int wl);
        int nb;
        nb = (bn == 0 || bn > NB) ? NB : bn;
        for (int i = 0; i < nb; i++) exp_q.push_back({4'(i), tab[i]});
        @(posedge clk); #1;
        beam_num = 5'(bn);
        win_len = 16'(wl);
        prt_start = 1'b1;
        @(posedge clk); #1;
        prt_start = 1'b0;
    endtask

    task automatic run_until_done(input int mode, input int budget, input int d0, input int ovr_at);
        data_in_valid = (mode == 0);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > d0) break;
            if (i == ovr_at) begin
                prt_start = 1'b1;
                beam_num = 5'd1;
                win_len = 16'd1;
            end else begin
                prt_start = 1'b0;
            end
            @(posedge clk); #1;
            if (mode == 1) data_in_valid = ~data_in_valid;
        end
        prt_start = 1'b0;
        data_in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({ph_real, ph_image, fy_cut_ctl, phase_data_valid, data_gate_valid, beam_idx,
             busy, frame_done, err_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {ph_real, ph_image, fy_cut_ctl,
                     phase_data_valid, data_gate_valid, beam_idx, busy, frame_done, err_overrun});
        end
        data_in_valid = 1'b1;
        prt_start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, data_gate_valid, err_overrun} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want 000", {busy, data_gate_valid, err_overrun});
        end
        prt_start = 1'b0;
        data_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, phase_data_valid, frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 000", {busy, phase_data_valid, frame_done});
        end
    endtask

    task automatic test_basic();
        int g0, d0, o0, nexp;
        for (int i = 0; i < 4; i++)
            write_entry(i, {3'($urandom_range(7, 0)), 16'($urandom), 16'($urandom)});
        g0 = gated_cnt; d0 = done_cnt; o0 = obs_q.size();
        start_frame(4, 8);
        nexp = exp_q.size();
        run_until_done(0, 200, d0, -1);
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d want 1", done_cnt - d0);
        end
        n_checks++;
        if (gated_cnt - g0 !== 32) begin
            n_fail++;
            $display("FAIL basic_gated: got %0d want 32", gated_cnt - g0);
        end
        n_checks++;
        if (done_cyc !== last_gv_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done_latency: got %0d want %0d", done_cyc, last_gv_cyc + 1);
        end
        n_checks++;
        if (obs_q.size() - o0 !== nexp) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d want %0d", obs_q.size() - o0, nexp);
        end
        for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
            logic [38:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[o0 + k] !== e) begin
                n_fail++;
                $display("FAIL basic_weights[%0d]: got %h want %h", k, obs_q[o0 + k], e);
            end
        end
        exp_q.delete();
        n_checks++;
        if ({busy, fy_cut_ctl, ph_real, ph_image} !== {1'b0, tab[3]}) begin
            n_fail++;
            $display("FAIL basic_hold: got %h want %h", {busy, fy_cut_ctl, ph_real, ph_image},
                     {1'b0, tab[3]});
        end
    endtask

    task automatic test_toggle();
        int g0, d0, o0, v0, nexp;
        g0 = gated_cnt; d0 = done_cnt; o0 = obs_q.size(); v0 = gvb_q.size();
        start_frame(2, 3);
        nexp = exp_q.size();
        run_until_done(1, 200, d0, -1);
        n_checks++;
        if (gated_cnt - g0 !== 6) begin
            n_fail++;
            $display("FAIL toggle_gated: got %0d want 6", gated_cnt - g0);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL toggle_done: got %0d want 1", done_cnt - d0);
        end
        for (int k = 0; k < 6 && (v0 + k) < gvb_q.size(); k++) begin
            n_checks++;
            if (gvb_q[v0 + k] !== 4'((k < 3) ? 0 : 1)) begin
                n_fail++;
                $display("FAIL toggle_beam_idx[%0d]: got %0d want %0d", k, gvb_q[v0 + k], (k < 3) ? 0 : 1);
            end
        end
        n_checks++;
        if (obs_q.size() - o0 !== nexp) begin
            n_fail++;
            $display("FAIL toggle_pulses: got %0d want %0d", obs_q.size() - o0, nexp);
        end
        for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
            logic [38:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[o0 + k] !== e) begin
                n_fail++;
                $display("FAIL toggle_weights[%0d]: got %h want %h", k, obs_q[o0 + k], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_overrun();
        int g0, d0, e0, o0, nexp;
        g0 = gated_cnt; d0 = done_cnt; e0 = err_cnt; o0 = obs_q.size();
        start_frame(4, 8);
        nexp = exp_q.size();
        run_until_done(0, 200, d0, 10);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_err: got %0d want 1", err_cnt - e0);
        end
        n_checks++;
        if (gated_cnt - g0 !== 32) begin
            n_fail++;
            $display("FAIL overrun_gated: got %0d want 32", gated_cnt - g0);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_done: got %0d want 1", done_cnt - d0);
        end
        n_checks++;
        if (obs_q.size() - o0 !== nexp) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d want %0d", obs_q.size() - o0, nexp);
        end
        for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
            logic [38:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[o0 + k] !== e) begin
                n_fail++;
                $display("FAIL overrun_weights[%0d]: got %h want %h", k, obs_q[o0 + k], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_clamp();
        int g0, d0, o0, nexp;
        int bn_tab [2];
        int wl_tab [2];
        bn_tab[0] = 0;  wl_tab[0] = 0;
        bn_tab[1] = 20; wl_tab[1] = 1;
        for (int i = 4; i < NB; i++)
            write_entry(i, {3'($urandom_range(7, 0)), 16'($urandom), 16'($urandom)});
        for (int t = 0; t < 2; t++) begin
            g0 = gated_cnt; d0 = done_cnt; o0 = obs_q.size();
            start_frame(bn_tab[t], wl_tab[t]);
            nexp = exp_q.size();
            run_until_done(0, 300, d0, -1);
            n_checks++;
            if (gated_cnt - g0 !== 16) begin
                n_fail++;
                $display("FAIL clamp_gated[%0d]: got %0d want 16", t, gated_cnt - g0);
            end
            n_checks++;
            if (done_cnt - d0 !== 1) begin
                n_fail++;
                $display("FAIL clamp_done[%0d]: got %0d want 1", t, done_cnt - d0);
            end
            n_checks++;
            if (obs_q.size() - o0 !== nexp) begin
                n_fail++;
                $display("FAIL clamp_pulses[%0d]: got %0d want %0d", t, obs_q.size() - o0, nexp);
            end
            for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
                logic [38:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (obs_q[o0 + k] !== e) begin
                    n_fail++;
                    $display("FAIL clamp_weights[%0d][%0d]: got %h want %h", t, k, obs_q[o0 + k], e);
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_rst_mid();
        int g0, d0, o0, nexp;
        logic hit;
        hit = 1'b0;
        d0 = done_cnt;
        start_frame(4, 8);
        data_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_gate_valid && beam_idx == 4'd2) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (hit !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_reach_beam2: got %b want 1", hit);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ph_real, ph_image, fy_cut_ctl, phase_data_valid, data_gate_valid, beam_idx,
             busy, frame_done, err_overrun} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h want 0", {ph_real, ph_image, fy_cut_ctl,
                     phase_data_valid, data_gate_valid, beam_idx, busy, frame_done, err_overrun});
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        data_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0);
        end
        g0 = gated_cnt; d0 = done_cnt; o0 = obs_q.size();
        start_frame(1, 2);
        nexp = exp_q.size();
        run_until_done(0, 100, d0, -1);
        n_checks++;
        if (gated_cnt - g0 !== 2 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL rstmid_restart: got gated=%0d done=%0d want gated=2 done=1",
                     gated_cnt - g0, done_cnt - d0);
        end
        n_checks++;
        if (obs_q.size() - o0 !== nexp) begin
            n_fail++;
            $display("FAIL rstmid_pulses: got %0d want %0d", obs_q.size() - o0, nexp);
        end
        for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
            logic [38:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[o0 + k] !== e) begin
                n_fail++;
                $display("FAIL rstmid_weights[%0d]: got %h want %h", k, obs_q[o0 + k], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_collision();
        int d0, o0, nexp;
        logic hit;
        logic [34:0] new_w;
        hit = 1'b0;
        new_w = ~tab[1];
        d0 = done_cnt; o0 = obs_q.size();
        data_in_valid = 1'b1;
        start_frame(2, 2);
        nexp = exp_q.size();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && beam_idx == 4'd1 && !data_gate_valid) begin
                hit = 1'b1;
                cfg_we = 1'b1;
                cfg_addr = 4'd1;
                {cfg_cut, cfg_real, cfg_imag} = new_w;
                @(posedge clk); #1;
                cfg_we = 1'b0;
                break;
            end
        end
        tab[1] = new_w;
        for (int i = 0; i < 100; i++) begin
            if (done_cnt > d0) break;
            @(posedge clk); #1;
        end
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (hit !== 1'b1 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL coll_frame: got hit=%b done=%0d want hit=1 done=1", hit, done_cnt - d0);
        end
        n_checks++;
        if (obs_q.size() - o0 !== nexp) begin
            n_fail++;
            $display("FAIL coll_pulses: got %0d want %0d", obs_q.size() - o0, nexp);
        end
        for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
            logic [38:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[o0 + k] !== e) begin
                n_fail++;
                $display("FAIL coll_old_weights[%0d]: got %h want %h", k, obs_q[o0 + k], e);
            end
        end
        exp_q.delete();
        d0 = done_cnt; o0 = obs_q.size();
        start_frame(2, 2);
        nexp = exp_q.size();
        run_until_done(0, 100, d0, -1);
        n_checks++;
        if (obs_q.size() - o0 !== nexp) begin
            n_fail++;
            $display("FAIL coll_next_pulses: got %0d want %0d", obs_q.size() - o0, nexp);
        end
        for (int k = 0; k < nexp && (o0 + k) < obs_q.size(); k++) begin
            logic [38:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[o0 + k] !== e) begin
                n_fail++;
                $display("FAIL coll_new_weights[%0d]: got %h want %h", k, obs_q[o0 + k], e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_overrun();
        test_clamp();
        test_rst_mid();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbf_fy_beam_sched.md
DBF_FY_BEAM_SCHED -- requirements
Module: dbf_fy_beam_sched

Interface
REQ-001 SHALL have parameter NBEAM, default 16, meaning number of beam weight table entries (power of 2).
REQ-002 SHALL have parameter AW, default 4, meaning table address width (log2 NBEAM).
REQ-003 SHALL have port clk  in  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_we  in  1  weight table write strobe.
REQ-006 SHALL have port cfg_addr  in  AW  weight table write address.
REQ-007 SHALL have port cfg_real / cfg_imag  in  16 each  weight components in fix16_13 format.
REQ-008 SHALL have port cfg_cut  in  3  per-beam truncation select.
REQ-009 SHALL have port beam_num  in  AW+1  number of beams per frame, sampled at frame start.
REQ-010 SHALL have port win_len  in  16  number of valid samples per beam, sampled at frame start.
REQ-011 SHALL have port prt_start  in  1  single-cycle frame start pulse.
REQ-012 SHALL have port data_in_valid  in  1  valid for the raw I/Q stream.
REQ-013 SHALL have ports ph_real / ph_image  out  16 each, phase_data_valid  out  1, fy_cut_ctl  out  3  to the weighting datapath.
REQ-014 SHALL have ports data_gate_valid  out  1, beam_idx  out  AW, busy  out  1, frame_done  out  1, err_overrun  out  1.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-016 SHALL move IDLE->LOAD on prt_start, latching beam_num and win_len and setting beam_idx=0.
REQ-017 SHALL clamp a latched beam_num of 0 or greater than NBEAM to NBEAM, and a latched win_len of 0 to 1.
REQ-018 SHALL, in LOAD (exactly one cycle), read entry beam_idx and register it onto ph_real, ph_image and fy_cut_ctl in the cycle after LOAD, with phase_data_valid=1 for that one cycle.
REQ-019 SHALL move LOAD->RUN unconditionally and clear the sample counter.
REQ-020 SHALL drive data_gate_valid = data_in_valid AND (state==RUN), combinationally with zero latency; it SHALL be 0 in all other states.
REQ-021 SHALL increment the sample counter on each gated valid; when the counter reaches win_len-1 with a valid, the FSM SHALL go to LOAD with beam_idx+1, or to DONE if beam_idx equals beam_num-1.
REQ-022 SHALL pulse frame_done for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL drive busy=1 in LOAD, RUN and DONE.
REQ-024 SHALL ignore prt_start when busy=1 and pulse err_overrun for one cycle.
REQ-025 SHALL accept table writes in any state; a write and a LOAD read of the same address in the same cycle SHALL return the old contents.
REQ-026 SHALL hold ph_real, ph_image and fy_cut_ctl stable between LOAD updates.
REQ-027 SHALL not change beam_num or win_len behaviour mid-frame; input changes take effect only at the next accepted prt_start.

Reset
REQ-028 SHALL, on rst, force state IDLE and set every output to 0: ph_real, ph_image, fy_cut_ctl, phase_data_valid, data_gate_valid, beam_idx, busy, frame_done, err_overrun.
REQ-029 SHALL abort a frame immediately when rst asserts mid-frame, with no frame_done pulse; weight table contents need not be cleared.

Structure
REQ-030 SHALL place the FSM state encoding, NBEAM and AW defaults in shared package dbf_sched_pkg.
REQ-031 SHALL instantiate the weight table as sub-module dbf_wt_ram: one write port and one synchronous read port, 35-bit words {cut, real, imag}.

Verification
REQ-032 SHALL cover: table entries 0..3 loaded, beam_num=4, win_len=8, continuous valid -> four phase_data_valid pulses with entries 0..3, 32 gated valids, frame_done 1 cycle after the 32nd.
REQ-033 SHALL cover: valid toggling 50% with win_len=3 and beam_num=2 -> exactly 6 gated valids, beam_idx changes only after the 3rd gated valid.
REQ-034 SHALL cover: prt_start during RUN -> err_overrun pulses once and the frame continues unchanged.
REQ-035 SHALL cover: beam_num=0 and win_len=0 -> 16 beams of 1 sample each.
REQ-036 SHALL cover: rst asserted mid-RUN at beam 2 -> all outputs 0 on the same edge, no frame_done, and the next prt_start restarts at beam 0.
REQ-037 SHALL cover: cfg write to entry 1 in the same cycle LOAD reads entry 1 -> old weights are output, and the new weights appear in the next frame.
